// File: rtl/sram_arbiter_512x32.sv
// Two-port arbiter in front of a single-port 512x32 SRAM with 1-cycle read latency.
// Port 0 has priority; port 1 is bounded by a consecutive-grant counter. Macro SRAM_ARB_WRITE_ACK_EN acknowledges writes on rvalid.
module sram_arbiter_512x32 #(
    parameter int MAX_CONSEC = 4,
    parameter int AW         = 9,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          sram_en,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);
`ifdef SRAM_ARB_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif

    logic [3:0] cnt;
    logic       vld_p1;
    logic       owner_p1;
    logic       we_p1;
    logic       rsp_p1;

    // Stage 0: arbitration and SRAM request mux
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (reset_n) begin
            if (p0_req && p1_req) begin
                if (cnt == MAX_CNT) p1_gnt = 1'b1;
                else                p0_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_en    = p0_gnt | p1_gnt;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (p0_gnt) begin
            sram_wen   = p0_we;
            sram_addr  = p0_addr;
            sram_wdata = p0_wdata;
        end else if (p1_gnt) begin
            sram_wen   = p1_we;
            sram_addr  = p1_addr;
            sram_wdata = p1_wdata;
        end
    end

    // Counter saturates implicitly: at MAX_CNT with both requesting, port 1 wins and it clears.
    always_ff @(posedge clk) begin
        if (!reset_n)                cnt <= 4'd0;
        else if (p0_gnt && p1_req)   cnt <= cnt + 4'd1;
        else                         cnt <= 4'd0;
    end

    // Stage 1: response owner pipe, aligned with SRAM read data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            owner_p1 <= 1'b0;
            we_p1    <= 1'b0;
        end else begin
            vld_p1   <= sram_en;
            owner_p1 <= p1_gnt;
            we_p1    <= sram_wen;
        end
    end

    // Gated by reset_n so an access granted just before reset never reports completion.
    assign rsp_p1    = vld_p1 && reset_n && (!we_p1 || WRITE_ACK);
    assign p0_rvalid = rsp_p1 && !owner_p1;
    assign p1_rvalid = rsp_p1 &&  owner_p1;
    assign p0_rdata  = (p0_rvalid && !we_p1) ? sram_rdata : '0;
    assign p1_rdata  = (p1_rvalid && !we_p1) ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter_512x32.sv
// Directed-vector bench for sram_arbiter_512x32 with a behavioural SRAM and a response scoreboard.
module tb_sram_arbiter_512x32;

`ifdef SRAM_ARB_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [8:0]  p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [8:0]  p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic        sram_en, sram_wen;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sbq[$];

    sram_arbiter_512x32 dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM, 1-cycle read latency
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_rdata     <= mem[sram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard when a response is due, flags any unexpected rvalid
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.port == 1'b0) begin
                chk("p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
                chk("p0_rdata", p0_rdata, e.data);
                chk("p1_rvalid_idle", {31'd0, p1_rvalid}, 32'd0);
            end else begin
                chk("p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
                chk("p1_rdata", p1_rdata, e.data);
                chk("p0_rvalid_idle", {31'd0, p0_rvalid}, 32'd0);
            end
        end else if (p0_rvalid || p1_rvalid) begin
            chk("unexpected_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        end
    end

    // One cycle of stimulus: drive after posedge, check grants/SRAM drive at negedge, queue responses
    task automatic step(input logic rn,
                        input logic r0, input logic w0, input logic [8:0] a0,
                        input logic [31:0] d0, input logic [31:0] x0,
                        input logic r1, input logic w1, input logic [8:0] a1,
                        input logic [31:0] d1, input logic [31:0] x1,
                        input logic g0, input logic g1, input logic kill);
        rsp_t e;
        @(posedge clk);
        #1;
        reset_n = rn;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        chk("p0_gnt", {31'd0, p0_gnt}, {31'd0, g0});
        chk("p1_gnt", {31'd0, p1_gnt}, {31'd0, g1});
        chk("sram_en", {31'd0, sram_en}, {31'd0, g0 | g1});
        chk("sram_wen", {31'd0, sram_wen}, g0 ? {31'd0, w0} : g1 ? {31'd0, w1} : 32'd0);
        chk("sram_addr", {23'd0, sram_addr}, g0 ? {23'd0, a0} : g1 ? {23'd0, a1} : 32'd0);
        chk("sram_wdata", sram_wdata, g0 ? d0 : g1 ? d1 : 32'd0);
        if (!kill && g0 && (!w0 || ACK)) begin
            e.port = 1'b0; e.data = w0 ? 32'd0 : x0; e.due = cyc + 1;
            sbq.push_back(e);
        end
        if (!kill && g1 && (!w1 || ACK)) begin
            e.port = 1'b1; e.data = w1 ? 32'd0 : x1; e.due = cyc + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 9'h000, 0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held with both ports requesting
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 9'h000, 0, 0, 1, 0, 9'h1A5, 0, 0, 0, 0, 0);
        // Release: port 0 wins immediately (write keeps memory initialised)
        step(1, 1, 1, 9'h000, 32'h11111111, 0, 1, 0, 9'h1A5, 0, 0, 1, 0, 0);
        idle();
        // Port 1 write then read of 0x1A5
        step(1, 0, 0, 9'h000, 0, 0, 1, 1, 9'h1A5, 32'hDEADBEEF, 0, 0, 1, 0);
        step(1, 0, 0, 9'h000, 0, 0, 1, 0, 9'h1A5, 0, 32'hDEADBEEF, 0, 1, 0);
        // Preload, then back-to-back port 0 reads
        step(1, 1, 1, 9'h001, 32'h22222222, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 1, 9'h1FF, 32'hFFFF0001, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 1, 9'h010, 32'hA5A5A5A5, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h000, 0, 32'h11111111, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h001, 0, 32'h22222222, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h1FF, 0, 32'hFFFF0001, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        idle();
        // Starvation bound: p0,p0,p0,p0,p1 repeating
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 9'h001, 0, 32'h22222222, 1, 0, 9'h1A5, 0, 32'hDEADBEEF,
                 (i % 5) != 4, (i % 5) == 4, 0);
        idle();
        // Read then write same address returns old data; write ack depends on build
        step(1, 1, 0, 9'h010, 0, 32'hA5A5A5A5, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 1, 9'h010, 32'h12345678, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h010, 0, 32'h12345678, 0, 0, 9'h000, 0, 0, 1, 0, 0);
        idle();
        // Build counter to 3, then reset right after a granted read
        step(1, 1, 0, 9'h000, 0, 32'h11111111, 1, 0, 9'h1A5, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h000, 0, 32'h11111111, 1, 0, 9'h1A5, 0, 0, 1, 0, 0);
        step(1, 1, 0, 9'h001, 0, 0, 1, 0, 9'h1A5, 0, 0, 1, 0, 1);
        step(0, 0, 0, 9'h000, 0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0);
        // Counter cleared: four port 0 grants before port 1
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 9'h1FF, 0, 32'hFFFF0001, 1, 0, 9'h1A5, 0, 32'hDEADBEEF,
                 i != 4, i == 4, 0);
        idle();
        idle();
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
